// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register built as a two-entry elastic buffer (main + skid).
// in_ready is a registered-state decode, so EX back-pressure never reaches ID combinationally.
module id_ex_skid_reg #(
  parameter int XLEN   = 64,
  parameter int RIDW   = 5,
  parameter int ALUOPW = 2,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_ctrl,
  input  logic [ALUOPW-1:0] in_aluop,
  input  logic [XLEN-1:0]   in_rs1data,
  input  logic [XLEN-1:0]   in_rs2data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [RIDW-1:0]   in_rs,
  input  logic [RIDW-1:0]   in_rt,
  input  logic [RIDW-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_ctrl,
  output logic [ALUOPW-1:0] out_aluop,
  output logic [XLEN-1:0]   out_rs1data,
  output logic [XLEN-1:0]   out_rs2data,
  output logic [XLEN-1:0]   out_imm,
  output logic [RIDW-1:0]   out_rs,
  output logic [RIDW-1:0]   out_rt,
  output logic [RIDW-1:0]   out_rd,
  output logic [CNTW-1:0]   stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

  typedef struct packed {
    logic [4:0]        ctrl;
    logic [ALUOPW-1:0] aluop;
    logic [XLEN-1:0]   rs1data;
    logic [XLEN-1:0]   rs2data;
    logic [XLEN-1:0]   imm;
    logic [RIDW-1:0]   rs;
    logic [RIDW-1:0]   rt;
    logic [RIDW-1:0]   rd;
  } entry_t;

  state_t          state_q, state_d;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  entry_t          cap;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic            in_fire, out_fire;

  // A write to x0 is architecturally a no-op, so drop RegWrite at capture time.
  function automatic logic [4:0] capture_ctrl(input logic [4:0] ctrl, input logic [RIDW-1:0] rd);
    logic [4:0] c;
    c = ctrl;
    if (rd == '0) c[2] = 1'b0;
    return c;
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  assign in_ready  = (state_q != SKID);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign cap = '{ctrl: capture_ctrl(in_ctrl, in_rd), aluop: in_aluop,
                 rs1data: in_rs1data, rs2data: in_rs2data, imm: in_imm,
                 rs: in_rs, rt: in_rt, rd: in_rd};

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = (out_valid && !out_ready) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = cap;
            state_d = FULL;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_d = cap;
          end else if (in_fire) begin
            skid_d  = cap;
            state_d = SKID;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Control fields read as a bubble when nothing is valid; data fields keep their last value.
  assign out_ctrl    = out_valid ? main_q.ctrl  : '0;
  assign out_aluop   = out_valid ? main_q.aluop : '0;
  assign out_rs1data = main_q.rs1data;
  assign out_rs2data = main_q.rs2data;
  assign out_imm     = main_q.imm;
  assign out_rs      = main_q.rs;
  assign out_rt      = main_q.rt;
  assign out_rd      = main_q.rd;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: directed scenarios plus randomized traffic against a queue-based model.
module tb_id_ex_skid_reg;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [1:0]  aluop;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } ent_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  ent_t drv;
  logic [4:0]  in_ctrl, in_rs, in_rt, in_rd;
  logic [1:0]  in_aluop;
  logic [63:0] in_rs1data, in_rs2data, in_imm;
  assign {in_ctrl, in_aluop, in_rs1data, in_rs2data, in_imm, in_rs, in_rt, in_rd} = drv;

  logic        in_ready, out_valid;
  logic [4:0]  out_ctrl, out_rs, out_rt, out_rd;
  logic [1:0]  out_aluop;
  logic [63:0] out_rs1data, out_rs2data, out_imm;
  logic [15:0] stall_cnt;
  ent_t        obs;
  assign obs = {out_ctrl, out_aluop, out_rs1data, out_rs2data, out_imm, out_rs, out_rt, out_rd};

  logic        d2_in_ready, d2_out_valid;
  logic [4:0]  d2_ctrl, d2_rs, d2_rt, d2_rd;
  logic [1:0]  d2_aluop;
  logic [63:0] d2_rs1, d2_rs2, d2_imm;
  logic [1:0]  stall_cnt2;

  id_ex_skid_reg #(.XLEN(64), .RIDW(5), .ALUOPW(2), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_aluop(in_aluop), .in_rs1data(in_rs1data), .in_rs2data(in_rs2data),
    .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_aluop(out_aluop),
    .out_rs1data(out_rs1data), .out_rs2data(out_rs2data), .out_imm(out_imm),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .stall_cnt(stall_cnt));

  id_ex_skid_reg #(.XLEN(64), .RIDW(5), .ALUOPW(2), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_ctrl(in_ctrl), .in_aluop(in_aluop), .in_rs1data(in_rs1data), .in_rs2data(in_rs2data),
    .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_ctrl(d2_ctrl), .out_aluop(d2_aluop),
    .out_rs1data(d2_rs1), .out_rs2data(d2_rs2), .out_imm(d2_imm),
    .out_rs(d2_rs), .out_rt(d2_rt), .out_rd(d2_rd), .stall_cnt(stall_cnt2));

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t q[$];
  ent_t m_last;
  int   m_stall, m_stall2;

  function automatic ent_t rand_ent();
    ent_t e;
    e.ctrl  = 5'($urandom);
    e.aluop = 2'($urandom);
    e.rs1   = {$urandom, $urandom};
    e.rs2   = {$urandom, $urandom};
    e.imm   = {$urandom, $urandom};
    e.rs    = 5'($urandom);
    e.rt    = 5'($urandom);
    e.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    return e;
  endfunction

  function automatic ent_t stored(input ent_t e);
    ent_t s;
    s = e;
    if (s.rd == 5'd0) s.ctrl[2] = 1'b0;
    return s;
  endfunction

  function automatic ent_t exp_view();
    ent_t e;
    if (q.size() > 0) e = q[0];
    else begin
      e = m_last;
      e.ctrl  = '0;
      e.aluop = '0;
    end
    return e;
  endfunction

  // Advance one clock: update the reference FIFO from the pre-edge inputs, sample 1ns after the edge.
  task automatic tick();
    bit inf, outf;
    inf  = in_valid && (q.size() < 2);
    outf = (q.size() > 0) && out_ready;
    if (q.size() > 0 && !out_ready) begin
      if (m_stall < 65535) m_stall++;
      if (m_stall2 < 3) m_stall2++;
    end
    if (flush) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(stored(drv));
    end
    if (q.size() > 0) m_last = q[0];
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    q.delete(); m_last = '0; m_stall = 0; m_stall2 = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1; drv = rand_ent();
    q.delete(); m_last = '0; m_stall = 0; m_stall2 = 0;
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL reset_handshake got=%b want=01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_payload got=%h want=0", obs); end
    n_checks++;
    if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
    in_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    drv = '0; drv.rd = 5'd3; drv.ctrl = 5'b00100; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_rd, out_ctrl} !== {1'b1, 5'd3, 5'b00100}) begin
      n_fail++; $display("FAIL single_out got=%b/%0d/%b want=1/3/00100", out_valid, out_rd, out_ctrl);
    end
    tick();
    n_checks++;
    if ({out_valid, out_ctrl, out_rd} !== {1'b0, 5'b00000, 5'd3}) begin
      n_fail++; $display("FAIL single_bubble got=%b/%b/%0d want=0/00000/3", out_valid, out_ctrl, out_rd);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drv = rand_ent(); drv.imm = 64'(i); in_valid = 1'b1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready i=%0d got=%b want=1", i, in_ready); end
      tick();
      n_checks++;
      if ({out_valid, out_imm} !== {1'b1, 64'(i)}) begin
        n_fail++; $display("FAIL stream_imm i=%0d got=%b/%0d want=1/%0d", i, out_valid, out_imm, i);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stream_stall got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_skid();
    apply_reset();
    drv = rand_ent(); drv.imm = 64'd10; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    drv = rand_ent(); drv.imm = 64'd11;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, out_imm} !== {1'b0, 1'b1, 64'd10}) begin
      n_fail++; $display("FAIL skid_enter got=%b/%b/%0d want=0/1/10", in_ready, out_valid, out_imm);
    end
    repeat (3) tick();
    n_checks++;
    if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL skid_stall got=%0d want=4", stall_cnt); end
    n_checks++;
    if (stall_cnt2 !== 2'd3) begin n_fail++; $display("FAIL skid_stall2 got=%0d want=3", stall_cnt2); end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, out_valid, out_imm} !== {1'b1, 1'b1, 64'd11}) begin
      n_fail++; $display("FAIL skid_drain1 got=%b/%b/%0d want=1/1/11", in_ready, out_valid, out_imm);
    end
    tick();
    n_checks++;
    if ({out_valid, stall_cnt} !== {1'b0, 16'd4}) begin
      n_fail++; $display("FAIL skid_drain2 got=%b/%0d want=0/4", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    drv = rand_ent(); tick();
    drv = rand_ent(); tick();
    flush = 1'b1; out_ready = 1'b1; drv = rand_ent();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_now got=%b want=01", {out_valid, in_ready});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_later cyc=%0d got=%b want=0", i, out_valid); end
    end
  endtask

  task automatic test_regwrite_x0();
    apply_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    drv = rand_ent(); drv.rd = 5'd0; drv.ctrl = 5'b11111;
    tick();
    n_checks++;
    if (out_ctrl !== 5'b11011) begin n_fail++; $display("FAIL x0_regwrite got=%b want=11011", out_ctrl); end
    drv = rand_ent(); drv.rd = 5'd7; drv.ctrl = 5'b00100;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_ctrl !== 5'b00100) begin n_fail++; $display("FAIL nz_regwrite got=%b want=00100", out_ctrl); end
  endtask

  task automatic test_saturate();
    apply_reset();
    drv = rand_ent(); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (stall_cnt2 !== 2'((k > 3) ? 3 : k)) begin
        n_fail++; $display("FAIL sat2 k=%0d got=%0d want=%0d", k, stall_cnt2, (k > 3) ? 3 : k);
      end
    end
    n_checks++;
    if (stall_cnt !== 16'd6) begin n_fail++; $display("FAIL sat16 got=%0d want=6", stall_cnt); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    drv = rand_ent(); drv.rd = 5'd9; tick();
    drv = rand_ent(); tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, stall_cnt, obs} !== {1'b0, 1'b1, 16'd0, ent_t'('0)}) begin
      n_fail++; $display("FAIL async_rst got=%b/%b/%0d/%h want=0/1/0/0", out_valid, in_ready, stall_cnt, obs);
    end
    q.delete(); m_last = '0; m_stall = 0; m_stall2 = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    drv = rand_ent(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, obs} !== {1'b1, stored(drv)}) begin
      n_fail++; $display("FAIL async_first_accept got=%b/%h want=1/%h", out_valid, obs, stored(drv));
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      drv       = rand_ent();
      tick();
      n_checks++;
      if ({out_valid, in_ready, obs} !== {q.size() > 0, q.size() < 2, exp_view()}) begin
        n_fail++;
        $display("FAIL rnd_bundle cyc=%0d got=%b%b_%h want=%b%b_%h", c, out_valid, in_ready, obs,
                 q.size() > 0, q.size() < 2, exp_view());
      end
      n_checks++;
      if ({stall_cnt, stall_cnt2} !== {m_stall[15:0], m_stall2[1:0]}) begin
        n_fail++; $display("FAIL rnd_stall cyc=%0d got=%0d/%0d want=%0d/%0d", c, stall_cnt, stall_cnt2, m_stall, m_stall2);
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    drv = '0;
    test_reset();
    test_single();
    test_stream();
    test_skid();
    test_flush();
    test_regwrite_x0();
    test_saturate();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_skid_reg.md
ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand and immediate width in bits.
REQ-002 SHALL have parameter RIDW, default 5, register-index width.
REQ-003 SHALL have parameter ALUOPW, default 2, ALU-op field width.
REQ-004 SHALL have parameter CNTW, default 16, stall-counter width.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset; assertion clears state immediately, deassertion takes effect at the next clk edge.
REQ-007 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-008 SHALL have port in_valid  input  1  upstream (ID) entry valid.
REQ-009 SHALL have port in_ready  output  1  block can accept an entry this cycle.
REQ-010 SHALL have port in_ctrl  input  5  {AluSrc, MemtoReg, RegWrite, MemRead, MemWrite}, MSB first.
REQ-011 SHALL have port in_aluop  input  ALUOPW  ALU-op field.
REQ-012 SHALL have ports in_rs1data, in_rs2data, in_imm  input  XLEN each  operands and immediate.
REQ-013 SHALL have ports in_rs, in_rt, in_rd  input  RIDW each  register indices.
REQ-014 SHALL have port out_valid  output  1  EX-side entry valid.
REQ-015 SHALL have port out_ready  input  1  EX stage consumes entry this cycle.
REQ-016 SHALL have ports out_ctrl, out_aluop, out_rs1data, out_rs2data, out_imm, out_rs, out_rt, out_rd  output  widths as matching inputs  registered payload.
REQ-017 SHALL have port stall_cnt  output  CNTW  count of back-pressure cycles.

Function
REQ-018 SHALL implement a 2-entry elastic buffer (main register + skid register) with FSM states EMPTY, FULL, SKID.
REQ-019 In-fire SHALL be in_valid && in_ready; out-fire SHALL be out_valid && out_ready.
REQ-020 in_ready SHALL be 1 in EMPTY and FULL, 0 in SKID, decoded from state only (no combinational path from out_ready).
REQ-021 out_valid SHALL be 1 in FULL and SKID, 0 in EMPTY; output payload SHALL always come from the main register.
REQ-022 EMPTY: in-fire -> load main, go FULL; else stay.
REQ-023 FULL: in-fire and out-fire -> load main, stay FULL; in-fire only -> load skid, go SKID; out-fire only -> go EMPTY; neither -> hold.
REQ-024 SKID: out-fire -> copy skid to main, go FULL; else hold both.
REQ-025 Latency in->out SHALL be exactly 1 cycle when EMPTY or FULL with out_ready=1; sustained throughput 1 entry/cycle.
REQ-026 On capture, if in_rd == 0 the stored RegWrite bit SHALL be forced to 0; all other fields stored unmodified.
REQ-027 When out_valid=0, out_ctrl and out_aluop SHALL read 0 (bubble); data/index outputs SHALL hold last main-register value.
REQ-028 flush=1 SHALL force next state EMPTY, overriding any simultaneous in-fire or out-fire; entry offered that cycle is dropped; in_ready remains as decoded from current state.
REQ-029 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturating at 2^CNTW-1; flush SHALL NOT clear it.
REQ-030 Entries SHALL leave in strict arrival order; no entry duplicated or lost except by flush.

Reset
REQ-031 While rst=0: state EMPTY, main and skid registers 0, stall_cnt 0, so out_valid=0, in_ready=1, all outputs 0.
REQ-032 Reset asserted mid-operation (any state) SHALL discard all entries asynchronously; first accept possible on the first clk edge after deassertion.

Verification
REQ-033 Reset, then in_valid=1, in_rd=3, in_ctrl=5'b00100, out_ready=1 for one cycle -> next cycle out_valid=1, out_rd=3, out_ctrl=5'b00100; following cycle out_valid=0, out_ctrl=0.
REQ-034 Stream 4 entries (imm 1..4) with out_ready=1 constantly -> out_imm 1,2,3,4 on consecutive cycles, in_ready never 0, stall_cnt=0.
REQ-035 FULL with imm=10, out_ready=0, push imm=11 -> state SKID, in_ready=0; hold 3 cycles -> stall_cnt=4; out_ready=1 -> out 10 then 11, in_ready=1 after first out-fire.
REQ-036 SKID holding two entries, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, no entry emitted later.
REQ-037 Push in_rd=0 with RegWrite=1 -> out_ctrl RegWrite bit=0, other bits unchanged.
REQ-038 CNTW=2, out_ready=0 with valid entry for 6 cycles -> stall_cnt saturates at 3; drop rst mid-SKID -> outputs 0 immediately, before next clk edge.
